// File: rtl/bmp_stream_writer.sv
// Streams one gray frame from a first-word-fall-through FIFO out as a complete 24-bpp BMP file.
// Build macro BMP_WR_CHECKSUM_EN adds a 32-bit running sum of every transferred byte.
module bmp_stream_writer #(
    parameter int WIDTH  = 720,
    parameter int HEIGHT = 540,
    parameter int PPM    = 2835
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        in_empty,
    input  logic [7:0]  in_dout,
    output logic        in_rd_en,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        busy,
`ifdef BMP_WR_CHECKSUM_EN
    output logic [31:0] checksum,
`endif
    output logic        done
);
    localparam int ROWB  = 3 * WIDTH;
    localparam int PAD_B = (4 - ROWB % 4) % 4;
    localparam int IMG   = (ROWB + PAD_B) * HEIGHT;
    localparam int FSIZE = 54 + IMG;
    localparam int CW    = $clog2(WIDTH + 1);
    localparam int RW    = $clog2(HEIGHT + 1);

    // Byte i of the header sits at bits [8*i +: 8]; multi-byte fields are little-endian.
    function automatic logic [431:0] build_hdr();
        logic [431:0] h;
        h = '0;
        h[0*8  +: 8]  = 8'h42;
        h[1*8  +: 8]  = 8'h4D;
        h[2*8  +: 32] = 32'(FSIZE);
        h[10*8 +: 32] = 32'd54;
        h[14*8 +: 32] = 32'd40;
        h[18*8 +: 32] = 32'(WIDTH);
        h[22*8 +: 32] = 32'(HEIGHT);
        h[26*8 +: 16] = 16'd1;
        h[28*8 +: 16] = 16'd24;
        h[34*8 +: 32] = 32'(IMG);
        h[38*8 +: 32] = 32'(PPM);
        h[42*8 +: 32] = 32'(PPM);
        return h;
    endfunction

    localparam logic [431:0] HDR = build_hdr();

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_PIX, S_PAD, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [5:0]      hdr_cnt;
    logic [CW-1:0]   col_cnt;
    logic [RW-1:0]   row_cnt;
    logic [1:0]      phase;
    logic [1:0]      pad_cnt;
    logic [7:0]      gray_q;
    logic            nxt_ok, nxt_last, load, xfer;
    logic [7:0]      nxt_byte;
    logic            last_col, last_row, last_pad;

    assign last_col = (col_cnt == CW'(WIDTH - 1));
    assign last_row = (row_cnt == RW'(HEIGHT - 1));
    assign last_pad = (pad_cnt == 2'(PAD_B - 1));
    assign xfer     = out_valid && out_ready;

    always_comb begin
        state_d  = state_q;
        nxt_ok   = 1'b0;
        nxt_byte = 8'h00;
        nxt_last = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_HDR;
            S_HDR: begin
                nxt_ok   = 1'b1;
                nxt_byte = HDR[{hdr_cnt, 3'b000} +: 8];
            end
            S_PIX: begin
                nxt_ok   = (phase != 2'd0) || !in_empty;
                nxt_byte = (phase == 2'd0) ? in_dout : gray_q;
                nxt_last = (phase == 2'd2) && last_col && last_row && (PAD_B == 0);
            end
            S_PAD: begin
                nxt_ok   = 1'b1;
                nxt_last = last_pad && last_row;
            end
            S_DONE: if (xfer && out_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // The output register refills in the same cycle it empties, so no bubble at full rate.
        load = nxt_ok && (!out_valid || out_ready);

        if (load) begin
            case (state_q)
                S_HDR: if (hdr_cnt == 6'd53) state_d = S_PIX;
                S_PIX: if (phase == 2'd2 && last_col)
                           state_d = (PAD_B != 0) ? S_PAD : (last_row ? S_DONE : S_PIX);
                S_PAD: if (last_pad) state_d = last_row ? S_DONE : S_PIX;
                default: ;
            endcase
        end
    end

    assign in_rd_en = load && (state_q == S_PIX) && (phase == 2'd0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            hdr_cnt   <= '0;
            col_cnt   <= '0;
            row_cnt   <= '0;
            phase     <= '0;
            pad_cnt   <= '0;
            gray_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= xfer && out_last;

            if (state_q == S_IDLE && start) begin
                busy    <= 1'b1;
                hdr_cnt <= '0;
                col_cnt <= '0;
                row_cnt <= '0;
                phase   <= '0;
                pad_cnt <= '0;
            end else if (xfer && out_last) begin
                busy <= 1'b0;
            end

            if (load) begin
                out_valid <= 1'b1;
                out_data  <= nxt_byte;
                out_last  <= nxt_last;
            end else if (xfer) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            if (load) begin
                case (state_q)
                    S_HDR: hdr_cnt <= hdr_cnt + 6'd1;
                    S_PIX: begin
                        if (phase == 2'd0) gray_q <= in_dout;
                        if (phase != 2'd2) begin
                            phase <= phase + 2'd1;
                        end else begin
                            phase <= 2'd0;
                            if (!last_col) begin
                                col_cnt <= col_cnt + 1'b1;
                            end else begin
                                col_cnt <= '0;
                                if (PAD_B == 0 && !last_row) row_cnt <= row_cnt + 1'b1;
                            end
                        end
                    end
                    S_PAD: begin
                        if (!last_pad) begin
                            pad_cnt <= pad_cnt + 2'd1;
                        end else begin
                            pad_cnt <= '0;
                            if (!last_row) row_cnt <= row_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef BMP_WR_CHECKSUM_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            checksum <= '0;
        end else if (state_q == S_IDLE && start) begin
            checksum <= '0;
        end else if (xfer) begin
            checksum <= checksum + 32'(out_data);
        end
    end
`endif

endmodule

// File: tb/tb_bmp_stream_writer.sv
// Bench for bmp_stream_writer: two instances (2x2 with row padding, 4x1 without) checked against
// a byte-position model of the BMP file fed from a bench-side FIFO.
module tb_bmp_stream_writer;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       start_s [2];
    logic       empty_s [2];
    logic       rd_s    [2];
    logic       valid_s [2];
    logic       ready_s [2];
    logic       last_s  [2];
    logic       busy_s  [2];
    logic       done_s  [2];
    logic [7:0] dout_s  [2];
    logic [7:0] data_s  [2];
    logic       force_empty [2];
`ifdef BMP_WR_CHECKSUM_EN
    logic [31:0] csum_s [2];
`endif

    int checks = 0;
    int failures = 0;

    logic [7:0] fifo_mem [2][256];
    logic [7:0] hdr_exp  [2][54];
    int avail    [2] = '{0, 0};
    int rd_ptr   [2] = '{0, 0};
    int pos      [2] = '{0, 0};
    int frames   [2] = '{0, 0};
    int pops     [2] = '{0, 0};
    int base     [2] = '{0, 0};
    bit in_frame [2] = '{1'b0, 1'b0};

    bmp_stream_writer #(.WIDTH(2), .HEIGHT(2), .PPM(2835)) dut0 (
        .clock(clock), .reset(reset), .start(start_s[0]), .in_empty(empty_s[0]),
        .in_dout(dout_s[0]), .in_rd_en(rd_s[0]), .out_valid(valid_s[0]), .out_ready(ready_s[0]),
        .out_data(data_s[0]), .out_last(last_s[0]), .busy(busy_s[0]),
`ifdef BMP_WR_CHECKSUM_EN
        .checksum(csum_s[0]),
`endif
        .done(done_s[0]));

    bmp_stream_writer #(.WIDTH(4), .HEIGHT(1), .PPM(2835)) dut1 (
        .clock(clock), .reset(reset), .start(start_s[1]), .in_empty(empty_s[1]),
        .in_dout(dout_s[1]), .in_rd_en(rd_s[1]), .out_valid(valid_s[1]), .out_ready(ready_s[1]),
        .out_data(data_s[1]), .out_last(last_s[1]), .busy(busy_s[1]),
`ifdef BMP_WR_CHECKSUM_EN
        .checksum(csum_s[1]),
`endif
        .done(done_s[1]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic put_le(input int g, input int at, input int nb, input int val);
        for (int i = 0; i < nb; i++) hdr_exp[g][at + i] = 8'((val >> (8 * i)) & 255);
    endtask

    task automatic build_hdr(input int g, input int w, input int h);
        int rowb, pad, img;
        rowb = 3 * w;
        pad  = (4 - rowb % 4) % 4;
        img  = (rowb + pad) * h;
        for (int i = 0; i < 54; i++) hdr_exp[g][i] = 8'h00;
        hdr_exp[g][0] = 8'h42;
        hdr_exp[g][1] = 8'h4D;
        put_le(g, 2, 4, 54 + img);
        put_le(g, 10, 4, 54);
        put_le(g, 14, 4, 40);
        put_le(g, 18, 4, w);
        put_le(g, 22, 4, h);
        put_le(g, 26, 2, 1);
        put_le(g, 28, 2, 24);
        put_le(g, 34, 4, img);
        put_le(g, 38, 4, 2835);
        put_le(g, 42, 4, 2835);
    endtask

    // Expected file byte at position p: header table, else pixel/pad derived from row geometry.
    function automatic logic [7:0] exp_byte(input int g, input int w, input int p);
        int rowb, rowlen, off, r, c;
        if (p < 54) return hdr_exp[g][p];
        rowb   = 3 * w;
        rowlen = rowb + (4 - rowb % 4) % 4;
        off    = p - 54;
        r      = off / rowlen;
        c      = off % rowlen;
        if (c >= rowb) return 8'h00;
        return fifo_mem[g][(base[g] + r * w + c / 3) % 256];
    endfunction

    // Hand-computed bytes for the first frame of each instance (lane 0 uses gray 10,20,30,40).
    function automatic int pin_val(input int g, input int p);
        if (g == 0) begin
            case (p)
                0: return 'h42;  1: return 'h4D;  2: return 'h46;  3: return 'h00;
                34: return 'h10; 54: return 'h0A; 57: return 'h14; 60: return 'h00;
                61: return 'h00; 62: return 'h1E; 65: return 'h28; 68: return 'h00;
                69: return 'h00;
                default: return -1;
            endcase
        end
        case (p)
            2: return 'h42;  18: return 'h04; 22: return 'h01; 34: return 'h0C;
            default: return -1;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int GW = (g == 0) ? 2 : 4;
        localparam int GH = (g == 0) ? 2 : 1;
        localparam int FS = 54 + (3 * GW + (4 - (3 * GW) % 4) % 4) * GH;

        assign empty_s[g] = force_empty[g] || (rd_ptr[g] >= avail[g]);
        assign dout_s[g]  = fifo_mem[g][rd_ptr[g] % 256];

        always @(posedge clock) if (rd_s[g] && !empty_s[g]) rd_ptr[g] <= rd_ptr[g] + 1;

        initial begin : cmp
            logic [7:0]  held_d;
            logic        held_l;
            logic [7:0]  eb;
            logic [31:0] csum_exp;
            bit          stalled, last_seen, accept;
            int          pv;
            stalled = 0; last_seen = 0; csum_exp = 0; held_d = 0; held_l = 0;
            forever begin
                @(negedge clock);
                if (!reset) begin
                    check("reset_outputs",
                          {rd_s[g], valid_s[g], last_s[g], busy_s[g], done_s[g], data_s[g]}, 32'd0);
                    in_frame[g] = 0; pos[g] = 0; stalled = 0; last_seen = 0;
                end else begin
                    check("done", done_s[g], last_seen);
`ifdef BMP_WR_CHECKSUM_EN
                    if (last_seen) check("checksum", csum_s[g], csum_exp);
`endif
                    check("busy", busy_s[g], in_frame[g]);
                    if (stalled) begin
                        check("hold_data", data_s[g], held_d);
                        check("hold_last", last_s[g], held_l);
                    end
                    check("pop_while_empty", rd_s[g] && empty_s[g], 0);
                    if (valid_s[g] && !ready_s[g]) check("pop_while_stalled", rd_s[g], 0);
                    if (rd_s[g]) pops[g]++;
                    accept    = start_s[g] && !in_frame[g];
                    last_seen = 0;
                    if (valid_s[g] && ready_s[g]) begin
                        eb = exp_byte(g, GW, pos[g]);
                        check("xfer_in_frame", in_frame[g], 1);
                        check("byte", data_s[g], eb);
                        check("last", last_s[g], pos[g] == FS - 1);
                        pv = pin_val(g, pos[g]);
                        if (frames[g] == 0 && pv >= 0) check("pin_byte", data_s[g], pv);
                        csum_exp += 32'(eb);
                        pos[g]++;
                        if (last_s[g]) begin
                            last_seen = 1;
                            check("frame_len", pos[g], (g == 0) ? 70 : 66);
                            check("pops", pops[g], GW * GH);
                            in_frame[g] = 0;
                            frames[g]++;
                        end
                    end
                    stalled = valid_s[g] && !ready_s[g];
                    held_d  = data_s[g];
                    held_l  = last_s[g];
                    if (accept) begin
                        in_frame[g] = 1; pos[g] = 0; pops[g] = 0;
                        base[g] = rd_ptr[g]; csum_exp = 0;
                    end
                end
            end
        end
    end

    task automatic push(input int g, input logic [7:0] v);
        fifo_mem[g][avail[g] % 256] = v;
        avail[g]++;
    endtask

    // Called just after a rising edge; start is raised immediately so back-to-back calls
    // land the next start in the done cycle of the previous frame.
    task automatic run_frame(input int g, input bit rnd_ready, input int stall_pos, input int busy_pos);
        int f0, n, scnt;
        bit busy_done;
        f0 = frames[g]; n = 0; scnt = 0; busy_done = 0;
        start_s[g] = 1'b1;
        while (frames[g] == f0 && n < 3000) begin
            @(posedge clock); #1;
            start_s[g] = 1'b0;
            ready_s[g] = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall_pos >= 0 && pos[g] >= stall_pos && scnt < 10) begin
                force_empty[g] = 1'b1;
                scnt++;
                if (!rnd_ready && scnt == 8) check("stall_valid_low", valid_s[g], 0);
            end else begin
                force_empty[g] = 1'b0;
            end
            if (busy_pos >= 0 && !busy_done && pos[g] >= busy_pos) begin
                start_s[g] = 1'b1;
                busy_done  = 1;
            end
            n++;
        end
        check("frame_complete", frames[g] != f0, 1);
        start_s[g] = 1'b0; ready_s[g] = 1'b1; force_empty[g] = 1'b0;
    endtask

    task automatic push_random(input int g, input int n);
        for (int i = 0; i < n; i++) push(g, 8'($urandom_range(0, 255)));
    endtask

    initial begin
        int n;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0; ready_s[i] = 1'b1; force_empty[i] = 1'b0;
        end
        build_hdr(0, 2, 2);
        build_hdr(1, 4, 1);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;

        push(0, 8'd10); push(0, 8'd20); push(0, 8'd30); push(0, 8'd40);
        run_frame(0, 0, -1, -1);

        push_random(1, 4);
        run_frame(1, 0, -1, -1);

        push_random(0, 4);
        run_frame(0, 0, 58, -1);

        push(0, 8'd10); push(0, 8'd20); push(0, 8'd30); push(0, 8'd40);
        run_frame(0, 1, -1, -1);

        push(0, 8'd10); push(0, 8'd20); push(0, 8'd30); push(0, 8'd40);
        run_frame(0, 0, -1, 20);

        for (int i = 0; i < 6; i++) begin
            int g;
            g = i % 2;
            push_random(g, (g == 0) ? 4 : 4);
            run_frame(g, 1, ($urandom_range(0, 1) == 1) ? 54 + $urandom_range(0, 8) : -1, -1);
        end

        push_random(0, 4);
        @(posedge clock); #1;
        start_s[0] = 1'b1;
        @(posedge clock); #1;
        start_s[0] = 1'b0;
        n = 0;
        while (pos[0] < 60 && n < 500) begin
            @(posedge clock); #1;
            n++;
        end
        check("abort_reached_pix", pos[0] >= 60, 1);
        #2 reset = 1'b0;
        #1 check("abort_outputs",
                 {rd_s[0], valid_s[0], last_s[0], busy_s[0], done_s[0], data_s[0]}, 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        push_random(0, 4);
        run_frame(0, 0, -1, -1);

        repeat (4) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
